data_mem_arbiter: RTL and testbench

- Shares the single RW port of the 1 KB data SRAM macro (sram_1rw1r_32_256_8_sky130, port 0) between two requesters: the ibex data port (core) and a fabric-side master driven through the eFPGA user I/O (fab).
- Generates real gnt/rvalid/err handshakes, replacing the constant rvalid tie-off.
- Sits in flexbex_soc_top between ibex_core, eFPGA_top and the SRAM.

---
 rtl/data_mem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/data_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data SRAM arbiter.
//   owner_e     : which requester a transfer or response belongs to
//   rsp_stage_t : contents of the one-deep response pipeline stage
//   WORD_OFF_W  : byte-offset bits dropped to form the SRAM word address
package data_mem_arb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_FAB  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_read;
    logic   err;
  } rsp_stage_t;

  localparam int WORD_OFF_W = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, resetn : clock, async active-low reset
//   en          : grant enable; no grant is issued while low
//   req[1:0]    : requests, bit 0 = core, bit 1 = fabric
//   gnt[1:0]    : one-hot (or zero) grant, combinational
// The pointer remembers the most recent winner; on a tie the other side wins.
// It resets to the fabric so the core takes the first conflict.
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) gnt = (ptr_q == OWN_FAB) ? 2'b01 : 2'b10;
      else                  gnt = req;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     ptr_q <= OWN_FAB;
    else if (gnt[0]) ptr_q <= OWN_CORE;
    else if (gnt[1]) ptr_q <= OWN_FAB;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the RW port of the data SRAM between the ibex data port (core_*)
// and a fabric master (fab_*), with gnt/rvalid/err handshakes.
//   clk, resetn      : clock, async active-low reset
//   core_* / fab_*   : requester ports (req/gnt/rvalid/err/we/be/addr/wdata/rdata)
//   fab_en_i         : fabric port enable, gates fab_req_i
//   sram_*           : SRAM port 0 drive; sram_dout_i valid the cycle after access
//   conflict_cnt_o   : saturating count of cycles with both requesters active
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int AW      = 12,
  parameter int SRAM_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               core_req_i,
  output logic               core_gnt_o,
  output logic               core_rvalid_o,
  output logic               core_err_o,
  input  logic               core_we_i,
  input  logic [3:0]         core_be_i,
  input  logic [AW-1:0]      core_addr_i,
  input  logic [31:0]        core_wdata_i,
  output logic [31:0]        core_rdata_o,
  input  logic               fab_en_i,
  input  logic               fab_req_i,
  output logic               fab_gnt_o,
  output logic               fab_rvalid_o,
  output logic               fab_err_o,
  input  logic               fab_we_i,
  input  logic [3:0]         fab_be_i,
  input  logic [AW-1:0]      fab_addr_i,
  input  logic [31:0]        fab_wdata_i,
  output logic [31:0]        fab_rdata_o,
  output logic               sram_csb_o,
  output logic               sram_web_o,
  output logic [3:0]         sram_wmask_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_din_o,
  input  logic [31:0]        sram_dout_i,
  output logic [CNT_W-1:0]   conflict_cnt_o
);

  logic              fab_req_eff;
  logic [1:0]        gnt;
  logic              accept;
  logic              sel_fab;
  logic              w_we;
  logic [3:0]        w_be;
  logic [AW-1:0]     w_addr;
  logic [31:0]       w_wdata;
  logic              in_range;
  logic              sram_acc;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]       din_q;
  rsp_stage_t        rsp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              unused_addr_bits;

  assign fab_req_eff = fab_req_i & fab_en_i;

  // Grants are held off while reset is asserted so every output sits at its
  // reset value even if a requester keeps its request up.
  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .en     (resetn),
    .req    ({fab_req_eff, core_req_i}),
    .gnt    (gnt)
  );

  assign core_gnt_o = gnt[0];
  assign fab_gnt_o  = gnt[1];
  assign accept     = |gnt;
  assign sel_fab    = gnt[1];

  assign w_we    = sel_fab ? fab_we_i    : core_we_i;
  assign w_be    = sel_fab ? fab_be_i    : core_be_i;
  assign w_addr  = sel_fab ? fab_addr_i  : core_addr_i;
  assign w_wdata = sel_fab ? fab_wdata_i : core_wdata_i;

  assign in_range         = ~|w_addr[AW-1:SRAM_AW+WORD_OFF_W];
  assign sram_acc         = accept & in_range;
  assign unused_addr_bits = ^w_addr[WORD_OFF_W-1:0];

  assign sram_csb_o   = ~sram_acc;
  assign sram_web_o   = ~(sram_acc & w_we);
  assign sram_wmask_o = (sram_acc && w_we) ? w_be : 4'b0000;
  assign sram_addr_o  = sram_acc ? w_addr[SRAM_AW+WORD_OFF_W-1:WORD_OFF_W] : addr_q;
  assign sram_din_o   = sram_acc ? w_wdata : din_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      din_q  <= '0;
    end else if (sram_acc) begin
      addr_q <= w_addr[SRAM_AW+WORD_OFF_W-1:WORD_OFF_W];
      din_q  <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid   <= accept;
      rsp_q.owner   <= sel_fab ? OWN_FAB : OWN_CORE;
      rsp_q.is_read <= ~w_we;
      rsp_q.err     <= ~in_range;
    end
  end

  assign core_rvalid_o = rsp_q.valid && (rsp_q.owner == OWN_CORE);
  assign fab_rvalid_o  = rsp_q.valid && (rsp_q.owner == OWN_FAB);
  assign core_err_o    = core_rvalid_o & rsp_q.err;
  assign fab_err_o     = fab_rvalid_o & rsp_q.err;
  assign core_rdata_o  = (core_rvalid_o && rsp_q.is_read && !rsp_q.err) ? sram_dout_i : 32'h0;
  assign fab_rdata_o   = (fab_rvalid_o && rsp_q.is_read && !rsp_q.err) ? sram_dout_i : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                   cnt_q <= '0;
    else if (core_req_i && fab_req_eff && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        core_req_i, core_gnt_o, core_rvalid_o, core_err_o, core_we_i;
  logic [3:0]  core_be_i;
  logic [11:0] core_addr_i;
  logic [31:0] core_wdata_i, core_rdata_o;
  logic        fab_en_i, fab_req_i, fab_gnt_o, fab_rvalid_o, fab_err_o, fab_we_i;
  logic [3:0]  fab_be_i;
  logic [11:0] fab_addr_i;
  logic [31:0] fab_wdata_i, fab_rdata_o;
  logic        sram_csb_o, sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_din_o, sram_dout_i;
  logic [15:0] conflict_cnt_o;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_err_o(core_err_o), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
    .fab_en_i(fab_en_i), .fab_req_i(fab_req_i), .fab_gnt_o(fab_gnt_o),
    .fab_rvalid_o(fab_rvalid_o), .fab_err_o(fab_err_o), .fab_we_i(fab_we_i),
    .fab_be_i(fab_be_i), .fab_addr_i(fab_addr_i), .fab_wdata_i(fab_wdata_i),
    .fab_rdata_o(fab_rdata_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
    .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i),
    .conflict_cnt_o(conflict_cnt_o)
  );

  // Behavioural SRAM port 0: masked write, read data registered.
  always @(posedge clk) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_din_o[8*b +: 8];
      end else begin
        sram_dout_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0;
    fab_req_i = 0; fab_we_i = 0; fab_be_i = 0; fab_addr_i = 0; fab_wdata_i = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  // Called at posedge+1. Drives one transfer, waits (bounded) for its grant,
  // checks the SRAM drive and then the response in the following cycle.
  task automatic xfer(input string tag, input bit fab, input bit we, input logic [3:0] be,
                      input logic [11:0] addr, input logic [31:0] wd,
                      input bit exp_err, input logic [31:0] exp_rd);
    int  n;
    bit  got;
    if (fab) begin
      fab_req_i = 1; fab_we_i = we; fab_be_i = be; fab_addr_i = addr; fab_wdata_i = wd;
    end else begin
      core_req_i = 1; core_we_i = we; core_be_i = be; core_addr_i = addr; core_wdata_i = wd;
    end
    #2;
    n = 0;
    got = fab ? fab_gnt_o : core_gnt_o;
    while (!got && n < 20) begin
      @(posedge clk); #3;
      n++;
      got = fab ? fab_gnt_o : core_gnt_o;
    end
    chk({tag, "_gnt"}, {31'b0, got}, 32'd1);
    if (got) begin
      chk({tag, "_csb"}, {31'b0, sram_csb_o}, {31'b0, exp_err});
      if (!exp_err) begin
        chk({tag, "_addr"}, {24'b0, sram_addr_o}, {24'b0, addr[9:2]});
        chk({tag, "_web"}, {31'b0, sram_web_o}, {31'b0, ~we});
        chk({tag, "_wmask"}, {28'b0, sram_wmask_o}, {28'b0, (we ? be : 4'b0000)});
      end
    end
    @(posedge clk); #1;
    if (fab) fab_req_i = 0; else core_req_i = 0;
    chk({tag, "_rvalid"}, {31'b0, (fab ? fab_rvalid_o : core_rvalid_o)}, 32'd1);
    chk({tag, "_err"}, {31'b0, (fab ? fab_err_o : core_err_o)}, {31'b0, exp_err});
    chk({tag, "_rdata"}, fab ? fab_rdata_o : core_rdata_o, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    idle_inputs();
    fab_en_i = 0;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_gnt", {31'b0, core_gnt_o}, 0);
    chk("rst_rvalid", {30'b0, core_rvalid_o, fab_rvalid_o}, 0);
    chk("rst_csb", {31'b0, sram_csb_o}, 1);
    chk("rst_web", {31'b0, sram_web_o}, 1);
    chk("rst_wmask", {28'b0, sram_wmask_o}, 0);
    chk("rst_addr", {24'b0, sram_addr_o}, 0);
    chk("rst_din", sram_din_o, 0);
    chk("rst_cnt", {16'b0, conflict_cnt_o}, 0);
    chk("rst_rdata", core_rdata_o | fab_rdata_o, 0);
    resetn = 1;
    @(posedge clk); #1;

    // 1: core-only read
    mem[5] = 32'hDEADBEEF;
    xfer("t1_rd", 0, 0, 4'hF, 12'h014, 0, 0, 32'hDEADBEEF);

    // 2: simultaneous writes straight after reset; core wins first
    do_reset();
    fab_en_i = 1;
    core_req_i = 1; core_we_i = 1; core_be_i = 4'hF; core_addr_i = 12'h000; core_wdata_i = 32'h11223344;
    fab_req_i = 1; fab_we_i = 1; fab_be_i = 4'hF; fab_addr_i = 12'h004; fab_wdata_i = 32'h55667788;
    #2;
    chk("t2_c0_core_gnt", {31'b0, core_gnt_o}, 1);
    chk("t2_c0_fab_gnt", {31'b0, fab_gnt_o}, 0);
    @(posedge clk); #1;
    core_req_i = 0;
    #2;
    chk("t2_c1_core_gnt", {31'b0, core_gnt_o}, 0);
    chk("t2_c1_fab_gnt", {31'b0, fab_gnt_o}, 1);
    chk("t2_c1_core_rvalid", {31'b0, core_rvalid_o}, 1);
    chk("t2_c1_fab_addr", {24'b0, sram_addr_o}, 1);
    @(posedge clk); #1;
    fab_req_i = 0;
    chk("t2_fab_rvalid", {31'b0, fab_rvalid_o}, 1);
    chk("t2_core_rvalid_low", {31'b0, core_rvalid_o}, 0);
    chk("t2_cnt", {16'b0, conflict_cnt_o}, 1);
    xfer("t2_rb_core", 0, 0, 4'hF, 12'h000, 0, 0, 32'h11223344);
    xfer("t2_rb_fab", 1, 0, 4'hF, 12'h004, 0, 0, 32'h55667788);

    // 3: byte enables and a be=0 write
    xfer("t3_wr_ff", 0, 1, 4'hF, 12'h000, 32'hFFFFFFFF, 0, 0);
    xfer("t3_wr_be", 0, 1, 4'b0010, 12'h000, 32'h0000AB00, 0, 0);
    xfer("t3_rd1", 0, 0, 4'hF, 12'h003, 0, 0, 32'hFFFFABFF);
    xfer("t3_wr_be0", 0, 1, 4'b0000, 12'h000, 32'h12345678, 0, 0);
    xfer("t3_rd2", 0, 0, 4'hF, 12'h000, 0, 0, 32'hFFFFABFF);

    // 4: out of range, from both sides
    xfer("t4_oor_core", 0, 0, 4'hF, 12'h400, 0, 1, 0);
    xfer("t4_oor_fab", 1, 1, 4'hF, 12'hFFC, 32'hAAAA5555, 1, 0);
    chk("t4_cnt", {16'b0, conflict_cnt_o}, 1);

    // 5: fabric gated off while core streams reads
    fab_en_i = 0;
    fab_req_i = 1; fab_we_i = 0; fab_addr_i = 12'h004;
    core_req_i = 1; core_we_i = 0; core_addr_i = 12'h000;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("t5_fab_gnt_%0d", i), {31'b0, fab_gnt_o}, 0);
      chk($sformatf("t5_core_gnt_%0d", i), {31'b0, core_gnt_o}, 1);
      @(posedge clk); #1;
    end
    chk("t5_cnt", {16'b0, conflict_cnt_o}, 1);
    core_req_i = 0;
    fab_en_i = 1;
    #2;
    chk("t5_fab_gnt_en", {31'b0, fab_gnt_o}, 1);
    @(posedge clk); #1;
    fab_req_i = 0;
    chk("t5_fab_rvalid", {31'b0, fab_rvalid_o}, 1);
    chk("t5_fab_rdata", fab_rdata_o, 32'h55667788);

    // 6: reset between acceptance and response
    @(posedge clk); #1;
    core_req_i = 1; core_we_i = 0; core_addr_i = 12'h014;
    #2;
    chk("t6_gnt", {31'b0, core_gnt_o}, 1);
    resetn = 0;
    #1;
    chk("t6_rst_gnt", {31'b0, core_gnt_o}, 0);
    chk("t6_rst_csb", {31'b0, sram_csb_o}, 1);
    @(posedge clk); #1;
    chk("t6_rst_rvalid", {30'b0, core_rvalid_o, fab_rvalid_o}, 0);
    chk("t6_rst_addr", {24'b0, sram_addr_o}, 0);
    chk("t6_rst_din", sram_din_o, 0);
    chk("t6_rst_cnt", {16'b0, conflict_cnt_o}, 0);
    core_req_i = 0;
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
    chk("t6_post_rvalid", {31'b0, core_rvalid_o}, 0);
    chk("t6_post_csb", {31'b0, sram_csb_o}, 1);
    // pointer back at FAB: core wins a conflict again
    core_req_i = 1; core_addr_i = 12'h000;
    fab_req_i = 1; fab_addr_i = 12'h004;
    #2;
    chk("t6_ptr_core", {31'b0, core_gnt_o}, 1);
    chk("t6_ptr_fab", {31'b0, fab_gnt_o}, 0);
    @(posedge clk); #1;
    idle_inputs();
    chk("t6_cnt_after", {16'b0, conflict_cnt_o}, 1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
